// File: rtl/adder_bist.sv
// Built-in self-test for a 4-operand adder: exhaustive operand sweep, golden compare, pass/fail report.
// Optional build macro ADDER_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module adder_bist #(
  parameter int WIDTH   = 4,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   op_c,
  output logic [WIDTH-1:0]   op_d,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_ov,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   test_num,
  output logic [4*WIDTH-1:0] first_fail
);

  localparam int VW = 4 * WIDTH;
  localparam int RW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [VW-1:0] vec;
  logic [1:0]    drain_cnt;
  logic          start_sweep, mismatch, stop;
  logic          cmp_valid;
  logic [VW-1:0] cmp_vec;
  logic [RW-1:0] cmp_exp;

  function automatic logic [RW-1:0] golden(input logic [VW-1:0] v);
    logic [WIDTH+1:0] full;
    full = (WIDTH+2)'(v[WIDTH-1:0])       + (WIDTH+2)'(v[2*WIDTH-1:WIDTH]) +
           (WIDTH+2)'(v[3*WIDTH-1:2*WIDTH]) + (WIDTH+2)'(v[4*WIDTH-1:3*WIDTH]);
    return {full[WIDTH+1:WIDTH] != 2'b00, full[WIDTH-1:0]};
  endfunction

  // Expected result travels alongside the DUT's own pipeline so both arrive at the same edge.
  generate
    if (DUT_LAT == 0) begin : g_comb
      assign cmp_valid = (state == RUN);
      assign cmp_vec   = vec;
      assign cmp_exp   = golden(vec);
    end else begin : g_pipe
      logic               launch;
      logic [DUT_LAT-1:0] pv;
      logic [VW-1:0]      pvec [DUT_LAT];
      logic [RW-1:0]      pexp [DUT_LAT];

      assign launch = (state == RUN);

      always_ff @(posedge clk) begin
        if (rst || stop) begin
          pv <= '0;
        end else begin
          pv[0] <= launch;
          for (int i = 1; i < DUT_LAT; i++) pv[i] <= pv[i-1];
        end
      end

      // NOTE: payload registers carry no reset; only the valid bits decide whether they are used.
      always_ff @(posedge clk) begin
        pvec[0] <= vec;
        pexp[0] <= golden(vec);
        for (int i = 1; i < DUT_LAT; i++) begin
          pvec[i] <= pvec[i-1];
          pexp[i] <= pexp[i-1];
        end
      end

      assign cmp_valid = pv[DUT_LAT-1];
      assign cmp_vec   = pvec[DUT_LAT-1];
      assign cmp_exp   = pexp[DUT_LAT-1];
    end
  endgenerate

  // Case inequality so an X on the DUT outputs is scored as a mismatch in simulation.
  assign mismatch    = cmp_valid && ({dut_ov, dut_sum} !== cmp_exp);
  assign start_sweep = start && (state == IDLE || state == DONE);

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (vec == '1) state_nxt = (DUT_LAT == 0) ? DONE : DRAIN;
      DRAIN:      if (drain_cnt == 2'(DUT_LAT - 1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (stop) state_nxt = DONE;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      drain_cnt  <= '0;
      fail_cnt   <= '0;
      test_num   <= '0;
      first_fail <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (start_sweep) begin
        vec        <= '0;
        fail_cnt   <= '0;
        test_num   <= '0;
        first_fail <= '0;
      end else begin
        if (state == RUN && vec != '1) vec <= vec + 1'b1;
        if (cmp_valid) begin
          test_num <= test_num + 1'b1;
          if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            if (fail_cnt == '0) first_fail <= cmp_vec;
          end
        end
      end
    end
  end

  assign op_a = vec[WIDTH-1:0];
  assign op_b = vec[2*WIDTH-1:WIDTH];
  assign op_c = vec[3*WIDTH-1:2*WIDTH];
  assign op_d = vec[4*WIDTH-1:3*WIDTH];
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (fail_cnt == '0);

endmodule
